// File: rtl/s2p_row_sched.sv
//------------------------------------------------------------------------------
// Module   : s2p_row_sched
// Brief    : Row scheduler for the double-banked serial-to-parallel buffer.
//            Optional stall statistics are enabled with S2P_STALL_CNT_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module s2p_row_sched #(
  parameter int DW = 32,
  parameter int DP = 56,
  parameter int CW = 6,
  parameter int RW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] cfg_cols,
  input  logic [RW-1:0] cfg_rows,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          wr_en,
  output logic          wr_bank,
  output logic [CW-1:0] wr_idx,
  output logic [DW-1:0] wr_data,
  output logic          row_valid,
  output logic          row_bank,
  output logic          row_last,
  input  logic          row_ready,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic [31:0]   stall_in_cnt,
  output logic [31:0]   stall_out_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic [1:0]    full_q, full_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] rows_in_q, rows_in_d;
  logic [RW-1:0] rows_out_q, rows_out_d;
  logic [CW-1:0] cols_q, cols_d;
  logic [RW-1:0] rows_q, rows_d;
  logic          done_q, done_d;
  logic          cfg_err_q, cfg_err_d;

  logic          cfg_ok;
  logic          start_ok;
  logic          in_fire;
  logic          row_fire;
  logic          col_last;
  logic          fill_last;
  logic          drain_last;

  assign cfg_ok     = (cfg_cols != '0) && (cfg_cols <= CW'(DP)) && (cfg_rows != '0);
  assign start_ok   = (state_q == S_IDLE) && start && cfg_ok && !abort;

  assign in_ready   = (state_q == S_FILL) && !full_q[wb_q];
  assign in_fire    = in_valid && in_ready;

  assign row_valid  = full_q[rb_q];
  assign row_bank   = rb_q;
  assign row_fire   = row_valid && row_ready;

  assign col_last   = (col_cnt_q == (cols_q - CW'(1)));
  assign fill_last  = (rows_in_q == (rows_q - RW'(1)));
  assign drain_last = (rows_out_q == (rows_q - RW'(1)));
  assign row_last   = row_valid && drain_last;

  // Write port is a pure pass-through of the accepted beat
  assign wr_en      = in_fire;
  assign wr_bank    = wb_q;
  assign wr_idx     = col_cnt_q;
  assign wr_data    = in_data;

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      full_q     <= 2'b00;
      col_cnt_q  <= '0;
      rows_in_q  <= '0;
      rows_out_q <= '0;
      cols_q     <= '0;
      rows_q     <= '0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      full_q     <= full_d;
      col_cnt_q  <= col_cnt_d;
      rows_in_q  <= rows_in_d;
      rows_out_q <= rows_out_d;
      cols_q     <= cols_d;
      rows_q     <= rows_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wb_d       = wb_q;
    rb_d       = rb_q;
    full_d     = full_q;
    col_cnt_d  = col_cnt_q;
    rows_in_d  = rows_in_q;
    rows_out_d = rows_out_q;
    cols_d     = cols_q;
    rows_d     = rows_q;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;

    if (abort) begin
      state_d    = S_IDLE;
      wb_d       = 1'b0;
      rb_d       = 1'b0;
      full_d     = 2'b00;
      col_cnt_d  = '0;
      rows_in_d  = '0;
      rows_out_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state_d    = S_FILL;
              cols_d     = cfg_cols;
              rows_d     = cfg_rows;
              wb_d       = 1'b0;
              rb_d       = 1'b0;
              full_d     = 2'b00;
              col_cnt_d  = '0;
              rows_in_d  = '0;
              rows_out_d = '0;
            end else begin
              cfg_err_d  = 1'b1;
            end
          end
        end

        default: begin
          if (in_fire) begin
            if (col_last) begin
              col_cnt_d    = '0;
              full_d[wb_q] = 1'b1;
              wb_d         = ~wb_q;
              rows_in_d    = rows_in_q + RW'(1);
              if (fill_last) begin
                state_d = S_DRAIN;
              end
            end else begin
              col_cnt_d = col_cnt_q + CW'(1);
            end
          end

          // Fill and drain always target different banks, so both may apply
          if (row_fire) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
            rows_out_d   = rows_out_q + RW'(1);
            if (drain_last) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef S2P_STALL_CNT_EN
  logic [31:0] stall_in_q;
  logic [31:0] stall_out_q;
  logic        stall_in_ev;
  logic        stall_out_ev;

  assign stall_in_ev  = in_valid && !in_ready && (state_q == S_FILL);
  assign stall_out_ev = row_valid && !row_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_in_q  <= '0;
      stall_out_q <= '0;
    end else if (abort || start_ok) begin
      stall_in_q  <= '0;
      stall_out_q <= '0;
    end else begin
      if (stall_in_ev && (stall_in_q != '1)) begin
        stall_in_q <= stall_in_q + 32'd1;
      end
      if (stall_out_ev && (stall_out_q != '1)) begin
        stall_out_q <= stall_out_q + 32'd1;
      end
    end
  end

  assign stall_in_cnt  = stall_in_q;
  assign stall_out_cnt = stall_out_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign stall_in_cnt    = '0;
  assign stall_out_cnt   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_s2p_row_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_s2p_row_sched
// Brief    : Directed self-checking bench for s2p_row_sched.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_s2p_row_sched;
  localparam int DW = 32;
  localparam int DP = 56;
  localparam int CW = 6;
  localparam int RW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] cfg_cols = '0;
  logic [RW-1:0] cfg_rows = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          wr_en;
  logic          wr_bank;
  logic [CW-1:0] wr_idx;
  logic [DW-1:0] wr_data;
  logic          row_valid;
  logic          row_bank;
  logic          row_last;
  logic          row_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic [31:0]   stall_in_cnt;
  logic [31:0]   stall_out_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  s2p_row_sched #(.DW(DW), .DP(DP), .CW(CW), .RW(RW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cfg_cols     (cfg_cols),
    .cfg_rows     (cfg_rows),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .wr_en        (wr_en),
    .wr_bank      (wr_bank),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data),
    .row_valid    (row_valid),
    .row_bank     (row_bank),
    .row_last     (row_last),
    .row_ready    (row_ready),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err),
    .stall_in_cnt (stall_in_cnt),
    .stall_out_cnt(stall_out_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bad_start(input int cols, input int rows, input string tag);
    cfg_cols = CW'(cols);
    cfg_rows = RW'(rows);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    #1;
    chk({tag, "_cfg_err"}, cfg_err, 1);
    chk({tag, "_busy"}, busy, 0);
    tick();
    chk({tag, "_cfg_err_clr"}, cfg_err, 0);
    chk({tag, "_busy_idle"}, busy, 0);
  endtask

  // Full frame with continuous input and an always-ready consumer.
  // A second start pulse is issued when word 'mid' is offered (mid < 0: none).
  task automatic run_stream(input int cols, input int rows, input int mid);
    int words;
    int rows_seen;
    int dones;
    int total;
    bit fin;
    words     = 0;
    rows_seen = 0;
    dones     = 0;
    fin       = 1'b0;
    total     = cols * rows;
    cfg_cols  = CW'(cols);
    cfg_rows  = RW'(rows);
    row_ready = 1'b1;
    in_valid  = 1'b0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < total + 50 && !fin; cyc++) begin
      in_valid = (words < total);
      in_data  = DW'(32'hA500_0000 + words);
      start    = (mid >= 0) && (words == mid);
      cfg_cols = start ? CW'(cols + 3) : CW'(cols);
      #1;
      if (in_valid && in_ready) begin
        chk("wr_en", wr_en, 1);
        chk("wr_idx", 32'(wr_idx), words % cols);
        chk("wr_bank", wr_bank, (words / cols) % 2);
        chk("wr_data", wr_data, 32'hA500_0000 + words);
        words++;
      end else begin
        chk("wr_en_idle", wr_en, 0);
      end
      if (row_valid) begin
        chk("row_bank", row_bank, rows_seen % 2);
        chk("row_last", row_last, (rows_seen == rows - 1));
        rows_seen++;
      end
      chk("no_cfg_err", cfg_err, 0);
      if (done) begin
        dones++;
        chk("busy_with_done", busy, 0);
        fin = 1'b1;
      end else begin
        chk("busy_in_frame", busy, 1);
      end
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    cfg_cols = CW'(cols);
    chk("words_total", words, total);
    chk("rows_total", rows_seen, rows);
    chk("done_count", dones, 1);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("done_single", done, 0);
      chk("busy_after", busy, 0);
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_row_valid", row_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_stall_in", stall_in_cnt, 0);
    chk("rst_stall_out", stall_out_cnt, 0);
    rst_n = 1'b1;
    tick();

    bad_start(0, 3, "cols0");
    bad_start(57, 3, "cols57");
    bad_start(4, 0, "rows0");

    run_stream(56, 3, -1);
    run_stream(4, 2, 2);
    run_stream(1, 1, -1);

    // Backpressure: consumer stalled, both banks fill, then one row drains
    cfg_cols  = CW'(4);
    cfg_rows  = RW'(4);
    row_ready = 1'b0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    acc       = 0;
    for (int cyc = 0; cyc < 13; cyc++) begin
      in_valid = 1'b1;
      in_data  = DW'(cyc);
      #1;
      if (in_valid && in_ready) acc++;
      tick();
    end
    row_ready = 1'b1;
    #1;
    chk("bp_accepted", acc, 8);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_row_valid", row_valid, 1);
    chk("bp_row_bank0", row_bank, 0);
`ifdef S2P_STALL_CNT_EN
    chk("bp_stall_in", stall_in_cnt, 5);
    chk("bp_stall_out", stall_out_cnt, 9);
`else
    chk("bp_stall_in", stall_in_cnt, 0);
    chk("bp_stall_out", stall_out_cnt, 0);
`endif
    tick();
    row_ready = 1'b0;
    #1;
    chk("bp_in_ready_back", in_ready, 1);
    chk("bp_row_bank1", row_bank, 1);
    chk("bp_row_valid1", row_valid, 1);
    chk("bp_refill_en", wr_en, 1);
    chk("bp_refill_bank", wr_bank, 0);
    chk("bp_refill_idx", 32'(wr_idx), 0);
    tick();
    in_valid = 1'b0;
    abort    = 1'b1;
    tick();
    abort    = 1'b0;
    #1;
    chk("bp_abort_busy", busy, 0);
    chk("bp_abort_row_valid", row_valid, 0);

    // Abort mid-frame after 10 words
    cfg_cols = CW'(8);
    cfg_rows = RW'(4);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    acc      = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_valid = 1'b1;
      in_data  = DW'(cyc);
      #1;
      if (in_valid && in_ready) acc++;
      tick();
    end
    chk("ab_accepted", acc, 10);
    chk("ab_row_valid_pre", row_valid, 1);
    in_valid = 1'b0;
    abort    = 1'b1;
    tick();
    abort    = 1'b0;
    #1;
    chk("ab_busy", busy, 0);
    chk("ab_row_valid", row_valid, 0);
    chk("ab_in_ready", in_ready, 0);
    chk("ab_done", done, 0);
    tick();
    chk("ab_done_later", done, 0);
    run_stream(8, 4, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/s2p_row_sched.md
Name: s2p_row_sched

Overview:
- Controller/scheduler for the serial-to-parallel row buffer in the RepVGG accelerator.
- Accepts a valid/ready stream of feature words and drives write strobe, bank and index into a double-banked serial-to-parallel buffer.
- Sequences completed rows to the downstream PE array with a row-level valid/ready handshake.
- Counts columns and rows per frame and signals frame completion.

Parameters:
- DW, 32, data word width.
- DP, 56, maximum words per row (buffer depth per bank).
- CW, 6, column counter / cfg_cols width; must satisfy 2^CW > DP.
- RW, 10, row counter / cfg_rows width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- start  input  1  frame start pulse; sampled only in IDLE.
- abort  input  1  synchronous frame abort.
- cfg_cols  input  CW  words per row; legal range 1..DP.
- cfg_rows  input  RW  rows per frame; legal range 1..2^RW-1.
- in_valid  input  1  input word valid.
- in_ready  output  1  input word accepted.
- in_data  input  DW  input word.
- wr_en  output  1  buffer write strobe.
- wr_bank  output  1  target bank.
- wr_idx  output  CW  word slot within the row.
- wr_data  output  DW  word to write.
- row_valid  output  1  a full row is available.
- row_bank  output  1  bank holding that row.
- row_last  output  1  presented row is the last row of the frame.
- row_ready  input  1  downstream consumed the row.
- busy  output  1  frame in progress.
- done  output  1  one-cycle frame-complete pulse.
- cfg_err  output  1  one-cycle pulse: start rejected.
- stall_in_cnt  output  32  input stall cycles (optional feature).
- stall_out_cnt  output  32  output stall cycles (optional feature).

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
- Reset values: state=IDLE, wb=rb=0, full[1:0]=0, col_cnt=0, rows_in=0, rows_out=0, done=0, cfg_err=0, stall counters=0. All outputs derived from these are therefore 0.
- States: IDLE, FILL, DRAIN.
- busy = (state != IDLE).
- IDLE, start=1:
  - cfg_cols in 1..DP and cfg_rows != 0: latch both, clear counters/banks/wb/rb, go to FILL next cycle.
  - Otherwise: cfg_err pulses the next cycle and state stays IDLE.
- start outside IDLE is ignored (no cfg_err).
- in_ready = (state==FILL) && !full[wb]. Combinational, no dependence on in_valid.
- On in_valid && in_ready (same cycle, combinational):
  - wr_en=1, wr_bank=wb, wr_idx=col_cnt, wr_data=in_data.
  - wr_en=0 otherwise; wr_bank/wr_idx/wr_data are don't-care when wr_en=0.
- Accepted word with col_cnt == cols-1:
  - col_cnt <= 0, full[wb] <= 1, wb toggles, rows_in++.
  - If rows_in == rows-1, state <= DRAIN.
- Any other accepted word: col_cnt++.
- row_valid = full[rb]; row_bank = rb; row_last = row_valid && (rows_out == rows-1).
- row_valid && row_ready: full[rb] <= 0, rb toggles, rows_out++.
  - If it is the last row: state <= IDLE and done=1 for exactly one cycle (the cycle after the handshake).
- Latency: row_valid rises 1 cycle after the handshake of the row's final word. A freed bank makes in_ready rise 1 cycle after the row handshake.
- Both banks full: in_ready=0 until a row handshake.
- Simultaneous fill-complete and row handshake in one cycle are always on different banks: full[wb]=0 is required to fill, full[rb]=1 is required to drain, so both updates apply.
- No further input is accepted in DRAIN or IDLE.
- abort (any state) has priority over start and handshakes: state <= IDLE, full <= 0, all counters <= 0, no done pulse. wr_en is still driven if a handshake occurs in the abort cycle, but that write is discarded.
- row_valid must not drop without row_ready, except on abort or reset.

Optional Feature:
- Macro S2P_STALL_CNT_EN.
- Defined:
  - stall_in_cnt increments each cycle with in_valid && !in_ready && state==FILL.
  - stall_out_cnt increments each cycle with row_valid && !row_ready.
  - Both clear on an accepted start and saturate at 2^32-1.
- Undefined: both ports tied to 0; no counter flops.

Test Plan:
- cols=56, rows=3, in_valid=1 continuous, row_ready=1 -> 168 words accepted with wr_idx cycling 0..55, wr_bank alternating 0,1,0. Three row handshakes, row_last on the third. done pulses once; busy falls with done.
- cols=4, rows=4, row_ready=0 -> in_ready drops after 8 words with full=2'b11. Raising row_ready for 1 cycle -> in_ready rises next cycle and bank 0 refills.
- start with cols=0, then with cols=57 -> cfg_err pulse each time, busy stays 0. start with cols=1, rows=1 -> one word, row_valid with row_last, done.
- abort after 10 words (cols=8, rows=4) -> IDLE next cycle, row_valid=0, no done. A new start runs cleanly from wr_idx=0, bank 0.
- start pulsed mid-frame -> ignored: counts, wb/rb unchanged, no cfg_err.
- S2P_STALL_CNT_EN, cols=4, rows=4, row_ready held 0 for 5 cycles while row_valid=1 and in_valid=1 -> stall_out_cnt=5, stall_in_cnt equals the cycles with both banks full. Without the macro both read 0.
